// File: rtl/csa_sbox_pkg.sv
// rtl/csa_sbox_pkg.sv - shared defaults and lane slice helpers for the s-box LUT engine
package csa_sbox_pkg;

  localparam int SBOX_NUM   = 7;
  localparam int SBOX_IN_W  = 5;
  localparam int SBOX_OUT_W = 2;
  localparam int SBOX_DEPTH = 2 ** SBOX_IN_W;

  // Lane i lookup address from a packed request word (default geometry).
  function automatic logic [SBOX_IN_W-1:0] lane_addr(
    input logic [SBOX_NUM*SBOX_IN_W-1:0] d,
    input int                            i
  );
    return d[i*SBOX_IN_W +: SBOX_IN_W];
  endfunction

  // Lane i result from a packed result word (default geometry).
  function automatic logic [SBOX_OUT_W-1:0] lane_res(
    input logic [SBOX_NUM*SBOX_OUT_W-1:0] d,
    input int                             i
  );
    return d[i*SBOX_OUT_W +: SBOX_OUT_W];
  endfunction

endpackage

// File: rtl/csa_sbox_lut.sv
// rtl/csa_sbox_lut.sv - one loadable lookup table with loaded bitmap and ready flag
module csa_sbox_lut #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clear,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic [IN_W-1:0]  rd_addr,
  output logic [OUT_W-1:0] rd_data,
  output logic             ready
);

  localparam int DEPTH = 2 ** IN_W;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] loaded;
  logic [DEPTH-1:0] loaded_nxt;
  logic [DEPTH-1:0] wr_bit;

  // Clear drops every loaded bit first; a same-cycle write then marks its own entry.
  always_comb begin
    wr_bit = '0;
    if (we) wr_bit[wr_addr] = 1'b1;
    loaded_nxt = (clear ? '0 : loaded) | wr_bit;
  end

  // Table storage has no reset so contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Bitmap and ready flag; ready is visible the cycle after the completing write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded <= '0;
      ready  <= 1'b0;
    end else begin
      loaded <= loaded_nxt;
      ready  <= &loaded_nxt;
    end
  end

  // Asynchronous read: a same-cycle write is seen only from the next cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/csa_sbox_lut_engine.sv
// rtl/csa_sbox_lut_engine.sv - bank of loadable s-box tables behind a 2-stage valid/ready pipeline
module csa_sbox_lut_engine
  import csa_sbox_pkg::*;
#(
  parameter int NUM_SBOX = SBOX_NUM,
  parameter int IN_W     = SBOX_IN_W,
  parameter int OUT_W    = SBOX_OUT_W,
  localparam int SEL_W   = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [SEL_W-1:0]          cfg_sel,
  input  logic [IN_W-1:0]           cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
  input  logic                      cfg_clear,
  output logic [NUM_SBOX-1:0]       tbl_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SBOX*IN_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SBOX*OUT_W-1:0] out_data,
  output logic [NUM_SBOX-1:0]       out_err
);

  logic                      s1_valid;
  logic [NUM_SBOX*IN_W-1:0]  s1_addr;
  logic                      s2_valid;
  logic [NUM_SBOX*OUT_W-1:0] s2_data;
  logic [NUM_SBOX-1:0]       s2_err;
  logic [NUM_SBOX*OUT_W-1:0] rd_bus;
  logic                      s2_load;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    logic lane_we;
    // Out-of-range selects match no lane and are silently dropped.
    assign lane_we = cfg_we && (cfg_sel == SEL_W'(i));

    csa_sbox_lut #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (lane_we),
      .clear   (cfg_clear),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_addr (s1_addr[i*IN_W +: IN_W]),
      .rd_data (rd_bus[i*OUT_W +: OUT_W]),
      .ready   (tbl_ready[i])
    );
  end

  assign s2_load  = ~s2_valid | out_ready;
  assign in_ready = ~s1_valid | ~s2_valid | out_ready;

  // S1 captures addresses, S2 captures table reads plus the readiness snapshot as error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= rd_bus;
          s2_err  <= ~tbl_ready;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_addr <= in_data;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_csa_sbox_lut_engine.sv
// tb/tb_csa_sbox_lut_engine.sv - table-driven self-checking bench for csa_sbox_lut_engine
module tb_csa_sbox_lut_engine;
  import csa_sbox_pkg::*;

  localparam int NS = 7;
  localparam int IW = 5;
  localparam int OW = 2;

  typedef struct {
    logic [NS*IW-1:0] in;
    logic [NS*OW-1:0] data;
    logic [NS-1:0]    err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [2:0]       cfg_sel;
  logic [IW-1:0]    cfg_addr;
  logic [OW-1:0]    cfg_data;
  logic             cfg_clear;
  logic [NS-1:0]    tbl_ready;
  logic             in_valid;
  logic             in_ready;
  logic [NS*IW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [NS*OW-1:0] out_data;
  logic [NS-1:0]    out_err;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] tm [NS][32];
  vec_t vq[$];

  always #5 clk = ~clk;

  csa_sbox_lut_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_clear (cfg_clear),
    .tbl_ready (tbl_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst_n = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    cfg_clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
  endtask

  task automatic cfg_write(input int sel, input int addr, input logic [OW-1:0] data);
    step();
    cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_addr = 5'(addr); cfg_data = data;
    if (sel < NS) tm[sel][addr] = data;
  endtask

  task automatic load_plain(input int t);
    for (int a = 0; a < 32; a++) cfg_write(t, a, 2'(a));
  endtask

  function automatic logic [NS*OW-1:0] exp_out(input logic [NS*IW-1:0] d);
    logic [NS*OW-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i*OW +: OW] = tm[i][lane_addr(d, i)];
    return r;
  endfunction

  // pat 0: out_ready always 1; pat 1: out_ready 1,0,0 repeating
  task automatic run_stream(input int pat, output int first_acc, output int first_out,
                            output int last_out);
    vec_t sb[$];
    vec_t e;
    int idx = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [NS*OW-1:0] prev_d = '0;
    logic [NS-1:0] prev_e = '0;
    first_acc = -1; first_out = -1; last_out = -1;
    while ((idx < vq.size() || sb.size() > 0) && cyc < 400) begin
      step();
      out_ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
      if (idx < vq.size()) begin
        in_valid = 1'b1;
        in_data  = vq[idx].in;
      end
      #1;
      chk("in_ready_rule", in_ready, (sb.size() < 2) || out_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_err", out_err, prev_e);
      end
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && sb.size() == 0) chk("no_duplicate", 1, 0);
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("result_data", out_data, e.data);
        chk("result_err", out_err, e.err);
        last_out = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_e = out_err;
      if (in_valid && in_ready) begin
        sb.push_back(vq[idx]);
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      cyc++;
    end
    chk("stream_no_timeout", cyc < 400, 1);
  endtask

  initial begin
    int fa, fo, lo;
    vec_t v;

    // 1: reset, then load table 0 with (a ^ 5'h1F)[1:0]
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b0;
    step(); #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_tbl_ready", tbl_ready, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_err", out_err, 0);
    for (int a = 0; a < 31; a++) cfg_write(0, a, 2'(a ^ 5'h1F));
    step(); #1;
    chk("t1_not_ready_before_last", tbl_ready, 7'h00);
    cfg_write(0, 31, 2'(31 ^ 5'h1F));
    step(); #1;
    chk("t1_ready_after_last", tbl_ready, 7'h01);

    // 2: all tables e[a] = a[1:0]; full-rate stream
    for (int t = 0; t < NS; t++) load_plain(t);
    step(); #1;
    chk("t2_all_ready", tbl_ready, 7'h7F);
    vq.delete();
    for (int n = 0; n < 32; n++) begin
      for (int i = 0; i < NS; i++) v.in[i*IW +: IW] = 5'((n + i) % 32);
      for (int i = 0; i < NS; i++) v.data[i*OW +: OW] = 2'((n + i) % 32);
      v.err = '0;
      vq.push_back(v);
    end
    run_stream(0, fa, fo, lo);
    chk("t2_latency", fo - fa, 2);
    chk("t2_throughput", lo - fo, 31);

    // 3: same stream with out_ready 1,0,0 pattern
    run_stream(1, fa, fo, lo);

    // 4: write/lookup collision on table 3 entry 0A
    step(); in_valid = 1'b1; in_data = {7{5'h0A}}; #1;
    chk("t4_accept_first", in_ready, 1);
    step(); in_valid = 1'b1; in_data = {7{5'h0A}};
    cfg_we = 1'b1; cfg_sel = 3'd3; cfg_addr = 5'h0A; cfg_data = 2'd1;
    tm[3][10] = 2'd1;
    step(); #1;
    chk("t4_old_valid", out_valid, 1);
    chk("t4_old_value", out_data, 14'h2AAA);
    step(); #1;
    chk("t4_new_valid", out_valid, 1);
    chk("t4_new_value", out_data, 14'h2A6A);
    step(); #1;
    chk("t4_drained", out_valid, 0);

    // 5: clear with same-cycle write, partial table 2, ignored out-of-range select
    step(); cfg_clear = 1'b1; cfg_we = 1'b1; cfg_sel = 3'd2; cfg_addr = 5'd4; cfg_data = 2'd3;
    tm[2][4] = 2'd3;
    step(); #1;
    chk("t5_cleared", tbl_ready, 7'h00);
    for (int t = 0; t < NS; t++) if (t != 2) load_plain(t);
    step(); #1;
    chk("t5_partial_ready", tbl_ready, 7'h7B);
    cfg_write(7, 4, 2'd1);
    step(); #1;
    chk("t5_sel7_bitmap", tbl_ready, 7'h7B);
    vq.delete();
    v.in = {7{5'd4}}; v.data = 14'h0030; v.err = 7'b0000100;
    vq.push_back(v);
    run_stream(0, fa, fo, lo);
    for (int a = 0; a < 32; a++) if (a != 4) cfg_write(2, a, 2'(a));
    step(); #1;
    chk("t5_clear_write_bit_kept", tbl_ready, 7'h7F);

    // 6: reset with both stages full and out_ready low
    step(); in_valid = 1'b1; in_data = {7{5'd6}}; out_ready = 1'b0;
    step(); in_valid = 1'b1; in_data = {7{5'd7}}; out_ready = 1'b0; #1;
    chk("t6_second_accept", in_ready, 1);
    step(); in_valid = 1'b1; in_data = {7{5'd8}}; out_ready = 1'b0; #1;
    chk("t6_full_in_ready", in_ready, 0);
    chk("t6_full_out_valid", out_valid, 1);
    rst_n = 1'b0; in_valid = 1'b0;
    step(); #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_tbl_ready", tbl_ready, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    vq.delete();
    v.in = {7{5'h13}}; v.data = 14'h3FFF; v.err = 7'h7F;
    vq.push_back(v);
    run_stream(0, fa, fo, lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
